lcd_spi_frame_receiver: RTL and testbench

//   Receiving end of the LCD 4-wire SPI link (cs/sclk/mosi/dc) driven by our LCD display masters.

---
 rtl/lcd_spi_frame_receiver.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lcd_spi_frame_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_frame_receiver.sv
// LCD 4-wire SPI receiver: oversampled deserialiser with
// CASET/RASET/RAMWR decode and per-pixel (x,y) strobes.
module lcd_spi_frame_receiver #(
  parameter int H_RES       = 240,
  parameter int V_RES       = 160,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_rst,
  input  logic        lcd_cs,
  input  logic        lcd_sclk,
  input  logic        lcd_mosi,
  input  logic        lcd_dc,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_in_range,
  output logic        frame_done
);

  localparam logic [15:0] H_LIM = 16'(H_RES);
  localparam logic [15:0] V_LIM = 16'(V_RES);
  localparam logic [15:0] XE_RST = H_LIM - 16'd1;
  localparam logic [15:0] YE_RST = V_LIM - 16'd1;
  localparam int SN = SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR,
    S_IGNORE
  } state_e;

  logic [SN-1:0] rst_sq, cs_sq, sclk_sq;
  logic [SN-1:0] mosi_sq, dc_sq;
  logic          sclk_prev_q;

  logic rst_s, cs_s, sclk_s, mosi_s, dc_s;
  logic rise, byte_done;
  logic [7:0] rx_byte;

  state_e      state_q, state_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [15:0] tmp_s_q, tmp_s_d;
  logic [7:0]  tmp_e_q, tmp_e_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d;
  logic [15:0] ys_q, ys_d, ye_q, ye_d;
  logic [15:0] cx_q, cx_d, cy_q, cy_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [7:0]  pix_x_q, pix_x_d;
  logic [7:0]  pix_y_q, pix_y_d;
  logic        pix_rng_q, pix_rng_d;
  logic        fdone_q, fdone_d;

  // Synchronisers stay out of the soft reset so lcd_rst can release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sq      <= '1;
      cs_sq       <= '1;
      sclk_sq     <= '0;
      mosi_sq     <= '0;
      dc_sq       <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      rst_sq      <= {rst_sq[SN-2:0], lcd_rst};
      cs_sq       <= {cs_sq[SN-2:0], lcd_cs};
      sclk_sq     <= {sclk_sq[SN-2:0], lcd_sclk};
      mosi_sq     <= {mosi_sq[SN-2:0], lcd_mosi};
      dc_sq       <= {dc_sq[SN-2:0], lcd_dc};
      sclk_prev_q <= sclk_s;
    end
  end

  assign rst_s  = rst_sq[SN-1];
  assign cs_s   = cs_sq[SN-1];
  assign sclk_s = sclk_sq[SN-1];
  assign mosi_s = mosi_sq[SN-1];
  assign dc_s   = dc_sq[SN-1];

  assign rise      = sclk_s & ~sclk_prev_q & ~cs_s;
  assign byte_done = rise & (bcnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    pcnt_d      = pcnt_q;
    tmp_s_d     = tmp_s_q;
    tmp_e_d     = tmp_e_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_rng_d   = pix_rng_q;
    fdone_d     = 1'b0;

    if (cs_s) begin
      bcnt_d  = 3'd0;
      phase_d = 1'b0;
    end else if (rise) begin
      shift_d = rx_byte[6:0];
      bcnt_d  = bcnt_q + 3'd1;
    end

    if (byte_done && !dc_s) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      pcnt_d      = 3'd0;
      unique case (1'b1)
        rx_byte == 8'h2A: state_d = S_CASET;
        rx_byte == 8'h2B: state_d = S_RASET;
        rx_byte == 8'h2C: begin
          state_d = S_RAMWR;
          cx_d    = xs_q;
          cy_d    = ys_q;
          phase_d = 1'b0;
        end
        default: state_d = S_IGNORE;
      endcase
    end else if (byte_done) begin
      unique case (state_q)
        S_CASET, S_RASET: begin
          if (pcnt_q != 3'd4) pcnt_d = pcnt_q + 3'd1;
          case (pcnt_q)
            3'd0: tmp_s_d[15:8] = rx_byte;
            3'd1: tmp_s_d[7:0]  = rx_byte;
            3'd2: tmp_e_d       = rx_byte;
            3'd3: begin
              if (state_q == S_CASET) begin
                xs_d = tmp_s_q;
                xe_d = {tmp_e_q, rx_byte};
              end else begin
                ys_d = tmp_s_q;
                ye_d = {tmp_e_q, rx_byte};
              end
            end
            default: ;
          endcase
        end
        S_RAMWR: begin
          if (!phase_q) begin
            hi_d    = rx_byte;
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            pix_valid_d = 1'b1;
            pix_data_d  = {hi_q, rx_byte};
            pix_x_d     = cx_q[7:0];
            pix_y_d     = cy_q[7:0];
            pix_rng_d   = (cx_q < H_LIM) &&
                          (cy_q < V_LIM);
            if (cx_q != xe_q) begin
              cx_d = cx_q + 16'd1;
            end else if (cy_q != ye_q) begin
              cx_d = xs_q;
              cy_d = cy_q + 16'd1;
            end else begin
              cx_d    = xs_q;
              cy_d    = ys_q;
              fdone_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (!rst_s) begin
      state_d     = S_IDLE;
      shift_d     = '0;
      bcnt_d      = '0;
      pcnt_d      = '0;
      tmp_s_d     = '0;
      tmp_e_d     = '0;
      xs_d        = '0;
      xe_d        = XE_RST;
      ys_d        = '0;
      ye_d        = YE_RST;
      cx_d        = '0;
      cy_d        = '0;
      phase_d     = 1'b0;
      hi_d        = '0;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = '0;
      pix_valid_d = 1'b0;
      pix_data_d  = '0;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_rng_d   = 1'b0;
      fdone_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bcnt_q      <= '0;
      pcnt_q      <= '0;
      tmp_s_q     <= '0;
      tmp_e_q     <= '0;
      xs_q        <= '0;
      xe_q        <= XE_RST;
      ys_q        <= '0;
      ye_q        <= YE_RST;
      cx_q        <= '0;
      cy_q        <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rng_q   <= 1'b0;
      fdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      pcnt_q      <= pcnt_d;
      tmp_s_q     <= tmp_s_d;
      tmp_e_q     <= tmp_e_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_rng_q   <= pix_rng_d;
      fdone_q     <= fdone_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_byte     = cmd_byte_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_in_range = pix_rng_q;
  assign frame_done   = fdone_q;

endmodule

// File: tb/tb_lcd_spi_frame_receiver.sv
// Directed bench for lcd_spi_frame_receiver: drives SPI
// byte sequences and checks captured pixel/command strobes.
module tb_lcd_spi_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_rst = 1'b1;
  logic        lcd_cs = 1'b1;
  logic        lcd_sclk = 1'b0;
  logic        lcd_mosi = 1'b0;
  logic        lcd_dc = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_in_range;
  logic        frame_done;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic        r;
    logic        f;
  } pix_t;

  pix_t pq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_cmd = 0;
  int   n_fd  = 0;

  lcd_spi_frame_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_rst      (lcd_rst),
    .lcd_cs       (lcd_cs),
    .lcd_sclk     (lcd_sclk),
    .lcd_mosi     (lcd_mosi),
    .lcd_dc       (lcd_dc),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_in_range (pix_in_range),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid)
      pq.push_back({pix_x, pix_y, pix_data,
                    pix_in_range, frame_done});
    if (cmd_valid) n_cmd++;
    if (frame_done) n_fd++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic spi_bits(input logic dc,
                          input logic [7:0] b,
                          input int n);
    lcd_cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      lcd_dc   = dc;
      lcd_mosi = b[7-i];
      lcd_sclk = 1'b0;
      repeat (4) @(negedge clk);
      lcd_sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    lcd_sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    spi_bits(1'b0, b, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    spi_bits(1'b1, b, 8);
  endtask

  task automatic pix(input logic [15:0] p);
    dat(p[15:8]);
    dat(p[7:0]);
  endtask

  task automatic exp_pix(input string tag,
                         input logic [7:0] x,
                         input logic [7:0] y,
                         input logic [15:0] d,
                         input logic r,
                         input logic f);
    pix_t e;
    if (pq.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      e = pq.pop_front();
      chk({tag, "_xy"}, {e.x, e.y}, {x, y});
      chk({tag, "_data"}, e.d, d);
      chk({tag, "_rng_fd"}, {e.r, e.f}, {r, f});
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {cmd_valid, cmd_byte, pix_valid,
              pix_data, pix_x, pix_y,
              pix_in_range, frame_done}, 64'd0);
  endtask

  initial begin
    logic [7:0] ex [7];
    logic [7:0] ey [7];
    ex = '{8'd10, 8'd11, 8'd12, 8'd10,
           8'd11, 8'd12, 8'd10};
    ey = '{8'd5, 8'd5, 8'd5, 8'd6,
           8'd6, 8'd6, 8'd5};

    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // default window, single pixel
    cmd(8'h2C);
    pix(16'hF800);
    settle();
    chk("t1_cmd_byte", cmd_byte, 8'h2C);
    chk("t1_ncmd", n_cmd, 1);
    exp_pix("t1", 8'd0, 8'd0, 16'hF800, 1'b1, 1'b0);

    // 3x2 window, wrap and frame_done
    cmd(8'h2A);
    dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
    cmd(8'h2B);
    dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++)
      pix(16'hA000 + 16'(i));
    settle();
    chk("t2_npix", pq.size(), 7);
    chk("t2_nfd", n_fd, 1);
    for (int i = 0; i < 7; i++)
      exp_pix($sformatf("t2_p%0d", i), ex[i], ey[i],
              16'hA000 + 16'(i), 1'b1, i == 5);

    // cs drop mid-byte clears partial and pending hi
    dat(8'hFF);
    spi_bits(1'b1, 8'hC0, 5);
    lcd_cs = 1'b1;
    repeat (10) @(negedge clk);
    pix(16'h1234);
    settle();
    chk("t3_npix", pq.size(), 1);
    exp_pix("t3", 8'd11, 8'd5, 16'h1234, 1'b1, 1'b0);

    // aborted CASET keeps old window
    cmd(8'h2A);
    dat(8'h00); dat(8'h00);
    cmd(8'h00);
    settle();
    chk("t4_cmd_byte", cmd_byte, 8'h00);
    cmd(8'h2C);
    pix(16'h0BEE);
    settle();
    exp_pix("t4", 8'd10, 8'd5, 16'h0BEE, 1'b1, 1'b0);

    // column beyond panel width
    cmd(8'h2A);
    dat(8'h00); dat(8'hFA); dat(8'h00); dat(8'hFA);
    cmd(8'h2C);
    pix(16'h5A5A);
    pix(16'hA5A5);
    settle();
    exp_pix("t5a", 8'd250, 8'd5, 16'h5A5A, 1'b0, 1'b0);
    exp_pix("t5b", 8'd250, 8'd6, 16'hA5A5, 1'b0, 1'b1);

    // soft reset mid-stream
    cmd(8'h2C);
    pix(16'hAAAA);
    dat(8'h77);
    lcd_rst = 1'b0;
    repeat (8) @(negedge clk);
    chk_outs_zero("t6_soft_outs");
    lcd_rst = 1'b1;
    repeat (8) @(negedge clk);
    exp_pix("t6a", 8'd250, 8'd5, 16'hAAAA, 1'b0, 1'b0);
    dat(8'hF0); dat(8'h0F);
    settle();
    chk("t6_ignored", pq.size(), 0);
    cmd(8'h2C);
    pix(16'h5555);
    settle();
    exp_pix("t6b", 8'd0, 8'd0, 16'h5555, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
